// File: rtl/ecc_point_add.sv
// Affine elliptic-curve point add/double over GF(p). An external unit inverts the slope
// denominator. Every product goes through one shared MSB-first shift-add modular multiplier.
module ecc_point_add #(
    parameter int integer_size = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic [integer_size-1:0] x1,
    input  logic [integer_size-1:0] y1,
    input  logic [integer_size-1:0] x2,
    input  logic [integer_size-1:0] y2,
    input  logic [integer_size-1:0] a,
    input  logic [integer_size-1:0] p,
    output logic [integer_size-1:0] x3,
    output logic [integer_size-1:0] y3,
    output logic                    done,
    output logic                    failure,
    output logic                    infinity,
    output logic                    inv_go,
    output logic [integer_size-1:0] inv_x,
    output logic [integer_size-1:0] inv_p,
    input  logic [integer_size-1:0] inv_x_inv,
    input  logic                    inv_done,
    input  logic                    inv_failure
);
    localparam int W  = integer_size;
    localparam int XW = integer_size + 2;
    localparam int CW = $clog2(integer_size + 1);

    typedef logic [W-1:0]  word_t;
    typedef logic [XW-1:0] wide_t;

    typedef enum logic [3:0] {
        S_IDLE, S_CLASSIFY, S_ADD_PREP, S_DBL_SQ, S_DBL_PREP, S_INV_REQ, S_INV_WAIT,
        S_LAMBDA, S_X3_SQ, S_X3_SUB, S_Y3_MUL, S_DONE
    } state_t;

    // Both operands are < m, so a single conditional correction is enough.
    function automatic word_t mod_add(input word_t u, input word_t v, input word_t m);
        wide_t s;
        s = wide_t'(u) + wide_t'(v);
        if (s >= wide_t'(m)) s = s - wide_t'(m);
        return s[W-1:0];
    endfunction

    function automatic word_t mod_sub(input word_t u, input word_t v, input word_t m);
        wide_t s;
        s = wide_t'(u) - wide_t'(v);
        if (u < v) s = s + wide_t'(m);
        return s[W-1:0];
    endfunction

    state_t         state_q, state_d;
    word_t          x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d, a_q, a_d, p_q, p_d;
    word_t          num_q, num_d, lambda_q, lambda_d;
    word_t          mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d;
    logic [CW-1:0]  mul_cnt_q, mul_cnt_d;
    word_t          x3_q, x3_d, y3_q, y3_d, inv_x_q, inv_x_d;
    logic           done_q, done_d, failure_q, failure_d, infinity_q, infinity_d;
    logic           inv_go_q, inv_go_d;

    word_t          mul_dbl, mul_nxt, mul_op_a, mul_op_b;
    logic           mul_busy, mul_last, mul_load;

    assign mul_busy = (state_q == S_DBL_SQ) || (state_q == S_LAMBDA) ||
                      (state_q == S_X3_SQ)  || (state_q == S_Y3_MUL);
    assign mul_last = mul_busy && (mul_cnt_q == CW'(1));
    assign mul_dbl  = mod_add(mul_acc_q, mul_acc_q, p_q);
    assign mul_nxt  = mul_a_q[W-1] ? mod_add(mul_dbl, mul_b_q, p_q) : mul_dbl;

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through the case can infer a latch.
        state_d    = state_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        a_d        = a_q;
        p_d        = p_q;
        num_d      = num_q;
        lambda_d   = lambda_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_acc_d  = mul_acc_q;
        mul_cnt_d  = mul_cnt_q;
        x3_d       = x3_q;
        y3_d       = y3_q;
        inv_x_d    = inv_x_q;
        failure_d  = failure_q;
        infinity_d = infinity_q;
        inv_go_d   = inv_go_q;
        mul_load   = 1'b0;
        mul_op_a   = '0;
        mul_op_b   = '0;

        if (mul_busy) begin
            mul_acc_d = mul_nxt;
            mul_a_d   = mul_a_q << 1;
            mul_cnt_d = mul_cnt_q - CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    x1_d       = x1;
                    y1_d       = y1;
                    x2_d       = x2;
                    y2_d       = y2;
                    a_d        = a;
                    p_d        = p;
                    failure_d  = 1'b0;
                    infinity_d = 1'b0;
                    state_d    = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                if (x1_q != x2_q) begin
                    state_d = S_ADD_PREP;
                end else if ((y1_q == y2_q) && (y1_q != '0)) begin
                    mul_load = 1'b1;
                    mul_op_a = x1_q;
                    mul_op_b = x1_q;
                    state_d  = S_DBL_SQ;
                end else begin
                    infinity_d = 1'b1;
                    x3_d       = '0;
                    y3_d       = '0;
                    state_d    = S_DONE;
                end
            end
            S_ADD_PREP: begin
                num_d    = mod_sub(y2_q, y1_q, p_q);
                inv_x_d  = mod_sub(x2_q, x1_q, p_q);
                inv_go_d = 1'b1;
                state_d  = S_INV_REQ;
            end
            S_DBL_SQ: begin
                if (mul_last) state_d = S_DBL_PREP;
            end
            S_DBL_PREP: begin
                // mul_acc_q holds x1^2 here; 3t+a is reduced one addend at a time.
                num_d    = mod_add(mod_add(mod_add(mul_acc_q, mul_acc_q, p_q), mul_acc_q, p_q),
                                   a_q, p_q);
                inv_x_d  = mod_add(y1_q, y1_q, p_q);
                inv_go_d = 1'b1;
                state_d  = S_INV_REQ;
            end
            S_INV_REQ, S_INV_WAIT: begin
                state_d = S_INV_WAIT;
                if (inv_done) begin
                    inv_go_d = 1'b0;
                    if (inv_failure) begin
                        failure_d = 1'b1;
                        x3_d      = '0;
                        y3_d      = '0;
                        state_d   = S_DONE;
                    end else begin
                        mul_load = 1'b1;
                        mul_op_a = num_q;
                        mul_op_b = inv_x_inv;
                        state_d  = S_LAMBDA;
                    end
                end
            end
            S_LAMBDA: begin
                if (mul_last) begin
                    lambda_d = mul_nxt;
                    mul_load = 1'b1;
                    mul_op_a = mul_nxt;
                    mul_op_b = mul_nxt;
                    state_d  = S_X3_SQ;
                end
            end
            S_X3_SQ: begin
                if (mul_last) begin
                    x3_d    = mod_sub(mod_sub(mul_nxt, x1_q, p_q), x2_q, p_q);
                    state_d = S_X3_SUB;
                end
            end
            S_X3_SUB: begin
                mul_load = 1'b1;
                mul_op_a = lambda_q;
                mul_op_b = mod_sub(x1_q, x3_q, p_q);
                state_d  = S_Y3_MUL;
            end
            S_Y3_MUL: begin
                if (mul_last) begin
                    y3_d    = mod_sub(mul_nxt, y1_q, p_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!go) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (mul_load) begin
            mul_a_d   = mul_op_a;
            mul_b_d   = mul_op_b;
            mul_acc_d = '0;
            mul_cnt_d = CW'(W);
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            a_q        <= '0;
            p_q        <= '0;
            num_q      <= '0;
            lambda_q   <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_acc_q  <= '0;
            mul_cnt_q  <= '0;
            x3_q       <= '0;
            y3_q       <= '0;
            inv_x_q    <= '0;
            done_q     <= 1'b0;
            failure_q  <= 1'b0;
            infinity_q <= 1'b0;
            inv_go_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from the values present before the edge.
            state_q    <= state_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            a_q        <= a_d;
            p_q        <= p_d;
            num_q      <= num_d;
            lambda_q   <= lambda_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_acc_q  <= mul_acc_d;
            mul_cnt_q  <= mul_cnt_d;
            x3_q       <= x3_d;
            y3_q       <= y3_d;
            inv_x_q    <= inv_x_d;
            done_q     <= done_d;
            failure_q  <= failure_d;
            infinity_q <= infinity_d;
            inv_go_q   <= inv_go_d;
        end
    end

    assign x3       = x3_q;
    assign y3       = y3_q;
    assign done     = done_q;
    assign failure  = failure_q;
    assign infinity = infinity_q;
    assign inv_go   = inv_go_q;
    assign inv_x    = inv_x_q;
    assign inv_p    = p_q;

endmodule

// File: tb/tb_ecc_point_add.sv
// Bench for ecc_point_add. It uses an integer-arithmetic point-add reference model and a
// brute-force inverse-unit responder. Operands are random, and a set of fixed cases covers
// the known edge conditions.
module tb_ecc_point_add;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, go;
    logic [W-1:0] x1, y1, x2, y2, a, p, x3, y3, inv_x, inv_p, inv_x_inv;
    logic         done, failure, infinity, inv_go, inv_done, inv_failure;

    int n_checks = 0;
    int n_pass   = 0;

    longint exp_x3, exp_y3, exp_inf, exp_fail, exp_den;
    int     exp_req;
    bit     exp_valid = 1'b0;

    bit force_fail  = 1'b0;
    int inv_lat     = 1;
    int req_cnt     = 0;
    int req_x       = 0;
    bit inv_served  = 1'b0;

    ecc_point_add #(.integer_size(W)) dut (
        .clk(clk), .reset(reset), .go(go),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .a(a), .p(p),
        .x3(x3), .y3(y3), .done(done), .failure(failure), .infinity(infinity),
        .inv_go(inv_go), .inv_x(inv_x), .inv_p(inv_p),
        .inv_x_inv(inv_x_inv), .inv_done(inv_done), .inv_failure(inv_failure)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint md(input longint v, input longint m);
        return ((v % m) + m) % m;
    endfunction

    // Inverse by Fermat's little theorem.
    function automatic longint fermat_inv(input longint d, input longint m);
        longint r, b, e;
        r = 1;
        b = md(d, m);
        e = m - 2;
        while (e > 0) begin
            if (e % 2 == 1) r = (r * b) % m;
            b = (b * b) % m;
            e = e / 2;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] brute_inv(input logic [W-1:0] v, input logic [W-1:0] m);
        for (int k = 1; k < int'(m); k++)
            if ((int'(v) * k) % int'(m) == 1) return k[W-1:0];
        return '0;
    endfunction

    task automatic model(input int mx1, input int my1, input int mx2, input int my2,
                         input int ma, input int mp,
                         output longint ex3, output longint ey3, output bit inf,
                         output longint den);
        longint lam;
        inf = 1'b0;
        ex3 = 0;
        ey3 = 0;
        den = 0;
        if (mx1 != mx2) begin
            den = md(mx2 - mx1, mp);
            lam = md(longint'(my2 - my1) * fermat_inv(den, mp), mp);
        end else if (my1 == my2 && my1 != 0) begin
            den = md(2 * my1, mp);
            lam = md((3 * longint'(mx1) * mx1 + ma) * fermat_inv(den, mp), mp);
        end else begin
            inf = 1'b1;
            return;
        end
        ex3 = md(lam * lam - mx1 - mx2, mp);
        ey3 = md(lam * (mx1 - ex3) - my1, mp);
    endtask

    // Inverse-unit responder.
    initial begin
        inv_done    = 1'b0;
        inv_failure = 1'b0;
        inv_x_inv   = '0;
        forever begin
            @(negedge clk);
            if (inv_go && !reset) begin
                req_cnt++;
                req_x = int'(inv_x);
                check("inv_p", longint'(inv_p), longint'(p));
                repeat (inv_lat) @(negedge clk);
                check("inv_go_held", longint'(inv_go), 1);
                inv_x_inv   = force_fail ? '0 : brute_inv(inv_x, inv_p);
                inv_failure = force_fail;
                inv_done    = 1'b1;
                @(negedge clk);
                inv_done    = 1'b0;
                inv_failure = 1'b0;
                check("inv_go_drop", longint'(inv_go), 0);
                inv_served  = 1'b1;
            end
        end
    end

    // Result comparison on every cycle done is high during an operation.
    always @(negedge clk) begin
        if (exp_valid && done) begin
            check("x3", longint'(x3), exp_x3);
            check("y3", longint'(y3), exp_y3);
            check("infinity", longint'(infinity), exp_inf);
            check("failure", longint'(failure), exp_fail);
            check("inv_go_in_done", longint'(inv_go), 0);
        end
    end

    task automatic run_op(input int ap, input int aa, input int ax1, input int ay1,
                          input int ax2, input int ay2, input bit fail, input int lat,
                          output int cyc);
        longint ex3, ey3, den;
        bit     inf;
        model(ax1, ay1, ax2, ay2, aa, ap, ex3, ey3, inf, den);
        exp_req    = inf ? 0 : 1;
        exp_fail   = (fail && !inf) ? 1 : 0;
        exp_inf    = inf ? 1 : 0;
        exp_x3     = (exp_fail != 0) ? 0 : ex3;
        exp_y3     = (exp_fail != 0) ? 0 : ey3;
        exp_den    = den;
        force_fail = fail;
        inv_lat    = lat;
        req_cnt    = 0;
        inv_served = 1'b0;
        @(negedge clk);
        x1 = W'(ax1);
        y1 = W'(ay1);
        x2 = W'(ax2);
        y2 = W'(ay2);
        a  = W'(aa);
        p  = W'(ap);
        go = 1'b1;
        exp_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 3000);
        check("done_seen", longint'(done), 1);
        repeat (2) @(negedge clk);
        go = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        check("done_fall", longint'(done), 0);
        check("inv_reqs", longint'(req_cnt), longint'(exp_req));
        if (exp_req != 0) check("inv_x", longint'(req_x), exp_den);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_x3"}, longint'(x3), 0);
        check({tag, "_y3"}, longint'(y3), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_failure"}, longint'(failure), 0);
        check({tag, "_infinity"}, longint'(infinity), 0);
        check({tag, "_inv_go"}, longint'(inv_go), 0);
        check({tag, "_inv_x"}, longint'(inv_x), 0);
    endtask

    initial begin
        int cyc;
        int k;
        int primes[6];
        primes = '{5, 7, 17, 97, 193, 251};
        reset = 1'b1;
        go = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; a = '0; p = 8'd17;
        repeat (2) @(negedge clk);
        check_zero_outputs("rst");
        reset = 1'b0;

        run_op(17, 2, 5, 1, 5, 1, 1'b0, 3, cyc);
        check("dbl_x3_lit", longint'(x3), 6);
        check("dbl_y3_lit", longint'(y3), 3);
        check("dbl_inv_x_lit", longint'(req_x), 2);
        check("dbl_req_lit", longint'(req_cnt), 1);

        run_op(17, 2, 5, 1, 6, 3, 1'b0, 5, cyc);
        check("add_x3_lit", longint'(x3), 10);
        check("add_y3_lit", longint'(y3), 6);
        check("add_inv_x_lit", longint'(req_x), 1);

        // Reset while the lambda multiply is running, then recover.
        force_fail = 1'b0;
        inv_lat    = 4;
        inv_served = 1'b0;
        req_cnt    = 0;
        @(negedge clk);
        x1 = 8'd5; y1 = 8'd1; x2 = 8'd6; y2 = 8'd3; a = 8'd2; p = 8'd17;
        go = 1'b1;
        k = 0;
        while (!inv_served && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("served_before_reset", longint'(inv_served), 1);
        @(negedge clk);
        reset = 1'b1;
        go = 1'b0;
        @(negedge clk);
        check_zero_outputs("midrst");
        reset = 1'b0;
        run_op(17, 2, 5, 1, 6, 3, 1'b0, 2, cyc);
        check("recover_x3_lit", longint'(x3), 10);
        check("recover_y3_lit", longint'(y3), 6);

        run_op(17, 2, 5, 1, 5, 16, 1'b0, 1, cyc);
        check("neg_inf_lit", longint'(infinity), 1);
        check("neg_x3_lit", longint'(x3), 0);
        check("neg_no_req", longint'(req_cnt), 0);
        check("neg_latency", longint'(cyc <= 3), 1);

        run_op(17, 2, 7, 0, 7, 0, 1'b0, 1, cyc);
        check("y0_inf_lit", longint'(infinity), 1);
        check("y0_no_req", longint'(req_cnt), 0);

        run_op(17, 2, 5, 1, 6, 3, 1'b1, 20, cyc);
        check("fail_lit", longint'(failure), 1);
        check("fail_x3_lit", longint'(x3), 0);
        check("fail_y3_lit", longint'(y3), 0);

        for (int i = 0; i < 40; i++) begin
            int pp, aa, ax1, ay1, ax2, ay2, mode;
            bit ff;
            pp   = primes[$urandom_range(0, 5)];
            aa   = int'($urandom_range(0, pp - 1));
            ax1  = int'($urandom_range(0, pp - 1));
            ay1  = int'($urandom_range(0, pp - 1));
            ax2  = int'($urandom_range(0, pp - 1));
            ay2  = int'($urandom_range(0, pp - 1));
            mode = int'($urandom_range(0, 9));
            ff   = 1'b0;
            if (mode == 5 || mode == 6) begin
                ax2 = ax1;
                ay2 = ay1;
            end else if (mode == 7) begin
                ax2 = ax1;
                ay2 = (pp - ay1) % pp;
            end else if (mode == 8) begin
                ax2 = ax1;
                ay1 = 0;
                ay2 = 0;
            end else if (mode == 9) begin
                ff = 1'b1;
            end
            run_op(pp, aa, ax1, ay1, ax2, ay2, ff, int'($urandom_range(1, 12)), cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
